// File: rtl/base_apack_pkg.sv
// rtl/base_apack_pkg.sv - default geometry shared by base_apack and its users
// Purpose: holds the default beat width and packing factor so that the packer
//          and the pipeline latch placed after it agree on one word layout.
// Ports:   none (package).
package base_apack_pkg;

  localparam int unsigned DEF_WIDTH   = 8;  // bits per narrow input beat
  localparam int unsigned DEF_WAYS    = 4;  // beats per packed output word
  localparam int unsigned DEF_LG_WAYS = 2;  // beat counter / o_c width

endpackage

// File: rtl/base_vlat.sv
// rtl/base_vlat.sv - free-running state latch with async active-low clear
// Purpose: stores d_i on every rising clock edge; clears while reset is low.
// Ports:   clk   - clock
//          reset - asynchronous clear, active low
//          d_i   - next value
//          q_o   - registered value
module base_vlat #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/base_vlat_en.sv
// rtl/base_vlat_en.sv - enabled state latch with async active-low clear
// Purpose: stores d_i on a rising clock edge when en_i is set; clears while
//          reset is low.
// Ports:   clk   - clock
//          reset - asynchronous clear, active low
//          en_i  - load enable
//          d_i   - next value
//          q_o   - registered value
module base_vlat_en #(
  parameter int unsigned width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q_q <= '0;
    else if (en_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/base_apack.sv
// rtl/base_apack.sv - valid/ready packer of narrow beats into one wide word
// Purpose: gathers up to `ways` beats of `width` bits into one word; a full
//          word or an end marker closes the word and hands it downstream.
//          Beat k sits at o_d[k*width +: width] (beat 0 at the low index end).
// Ports:   clk   - clock, all state on rising edge
//          reset - asynchronous clear, active low
//          i_v/i_d/i_e/i_r - input beat valid, data, end marker, ready
//          o_v/o_d/o_c/o_e/o_r - output valid, packed word, beats-1,
//                                closed-by-end flag, downstream ready
module base_apack
  import base_apack_pkg::*;
#(
  parameter int unsigned width   = DEF_WIDTH,
  parameter int unsigned ways    = DEF_WAYS,
  parameter int unsigned lg_ways = DEF_LG_WAYS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  input  logic [0:width-1]      i_d,
  input  logic                  i_e,
  output logic                  i_r,
  output logic                  o_v,
  output logic [0:ways*width-1] o_d,
  output logic [0:lg_ways-1]    o_c,
  output logic                  o_e,
  input  logic                  o_r
);

  localparam int unsigned WW = ways * width;
  localparam int unsigned OW = WW + lg_ways + 1;
  localparam logic [lg_ways-1:0] LAST = lg_ways'(ways - 1);

  logic [lg_ways-1:0] cnt_q, cnt_d;
  logic [0:WW-1]      asm_q;
  logic [0:width-1]   lane_d;
  logic [ways-1:0]    lane_en;
  logic [0:WW-1]      word_d;
  logic [OW-1:0]      out_q, out_d;
  logic               ov_q, ov_d;

  logic final_cand, xfer, load, advance;

  // A beat closes the word when it is marked as the end or fills the last
  // lane. Only such beats can be blocked, and only by an undrained word.
  assign final_cand = i_e | (cnt_q == LAST);
  assign i_r        = ~final_cand | ~ov_q | o_r;
  assign xfer       = i_v & i_r;
  assign load       = xfer & final_cand;
  assign advance    = xfer & ~final_cand;

  // Beat counter: steps on each accepted non-final beat, clears on a final one.
  assign cnt_d = load ? '0 : cnt_q + lg_ways'(1);

  base_vlat_en #(.width(lg_ways)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en_i  (xfer),
    .d_i   (cnt_d),
    .q_o   (cnt_q)
  );

  // Assembly lanes: the addressed lane captures a non-final beat; every lane
  // clears when the word is handed off, so unfilled lanes always read zero.
  assign lane_d = load ? '0 : i_d;

  for (genvar k = 0; k < ways; k++) begin : g_lane
    assign lane_en[k] = load | (advance & (cnt_q == lg_ways'(k)));

    base_vlat_en #(.width(width)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en_i  (lane_en[k]),
      .d_i   (lane_d),
      .q_o   (asm_q[k*width +: width])
    );
  end

  // Closing word: lanes below cnt from the buffer, the current beat at cnt,
  // zero above it. The current beat bypasses the buffer so the word is ready
  // on the same edge that accepts the final beat.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (lg_ways'(k) < cnt_q)       word_d[k*width +: width] = asm_q[k*width +: width];
      else if (lg_ways'(k) == cnt_q) word_d[k*width +: width] = i_d;
    end
  end

  assign out_d = {word_d, cnt_q, i_e};

  base_vlat_en #(.width(OW)) u_out (
    .clk   (clk),
    .reset (reset),
    .en_i  (load),
    .d_i   (out_d),
    .q_o   (out_q)
  );

  // Valid stays up across a drain-and-reload edge, so words flow without a
  // bubble.
  assign ov_d = load | (ov_q & ~o_r);

  base_vlat #(.width(1)) u_ov (
    .clk   (clk),
    .reset (reset),
    .d_i   (ov_d),
    .q_o   (ov_q)
  );

  assign o_v = ov_q;
  assign o_d = out_q[OW-1 -: WW];
  assign o_c = out_q[lg_ways:1];
  assign o_e = out_q[0];

endmodule
